hit_conditioner: RTL

HIT_CONDITIONER -- requirements
Module: hit_conditioner

---
 rtl/hit_conditioner.sv | 119 +++++++++++
 1 files changed

// File: rtl/hit_conditioner.sv
// Synchronises a detector pulse, qualifies it by minimum width, and latches it for the controller.
// It also queues one further hit, applies a dead time after each acknowledge, and counts hits lost to overflow.
module hit_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 2,
  parameter int DEAD_TIME   = 4,
  parameter int MISS_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit_in,
  input  logic              enable,
  input  logic              hit_reset,
  input  logic              miss_clear,
  output logic              hit_latched,
  output logic              hit_pending,
  output logic              dead,
  output logic [MISS_W-1:0] miss_count
);

  localparam logic [3:0] W_LAST    = 4'(MIN_WIDTH - 1);
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_TIME - 1);

  typedef enum logic [1:0] {IDLE, LATCHED, DEAD} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [3:0]             wcnt;
  logic                   done;
  logic                   qual;
  logic                   pend_n;
  logic [7:0]             dcnt, dcnt_n;
  logic                   miss_inc;

  assign s = sync[SYNC_STAGES-1];
  // done suppresses further events while the counter sits saturated in the same s-high run.
  assign qual = s && (wcnt == W_LAST) && !done && enable;

  always_comb begin
    state_n  = state;
    pend_n   = hit_pending;
    dcnt_n   = dcnt;
    miss_inc = 1'b0;
    case (state)
      IDLE: begin
        if (qual) state_n = LATCHED;
      end
      LATCHED: begin
        if (hit_reset) begin
          state_n = DEAD;
          dcnt_n  = DEAD_LAST;
        end
        if (qual) begin
          if (hit_pending) miss_inc = 1'b1;
          else             pend_n   = 1'b1;
        end
      end
      DEAD: begin
        if (dcnt == 8'd0) begin
          // An event arriving on the exit cycle becomes the new queued or latched hit.
          if (hit_pending) begin
            state_n = LATCHED;
            pend_n  = qual;
          end else if (qual) begin
            state_n = LATCHED;
          end else begin
            state_n = IDLE;
          end
        end else begin
          dcnt_n = dcnt - 8'd1;
          if (qual) begin
            if (hit_pending) miss_inc = 1'b1;
            else             pend_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!enable) begin
      state_n = IDLE;
      pend_n  = 1'b0;
      dcnt_n  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= '0;
      wcnt        <= 4'd0;
      done        <= 1'b0;
      state       <= IDLE;
      dcnt        <= 8'd0;
      hit_latched <= 1'b0;
      hit_pending <= 1'b0;
      dead        <= 1'b0;
      miss_count  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], hit_in};
      if (!s) begin
        wcnt <= 4'd0;
        done <= 1'b0;
      end else begin
        if (wcnt != W_LAST) wcnt <= wcnt + 4'd1;
        else                done <= 1'b1;
      end
      state       <= state_n;
      dcnt        <= dcnt_n;
      hit_latched <= (state_n == LATCHED);
      dead        <= (state_n == DEAD);
      hit_pending <= pend_n;
      if (miss_clear)
        miss_count <= '0;
      else if (miss_inc && !(&miss_count))
        miss_count <= miss_count + MISS_W'(1);
    end
  end

endmodule
